// File: rtl/set_time_ctrl.sv
// Time-set front end: conditions a push button (sync, debounce, hold-to-repeat) and
// steps the selected hour/minute/second field, seeding from the running clock on set entry.
module set_time_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16,
  parameter int unsigned HOUR_MODE_24    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pb,
  input  logic       set_en,
  input  logic [1:0] field_sel,
  input  logic       dir,
  input  logic [4:0] cur_h,
  input  logic [5:0] cur_m,
  input  logic [5:0] cur_s,
  output logic [4:0] h_in,
  output logic [5:0] m_in,
  output logic [5:0] s_in,
  output logic       set_strobe
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RpW    = $clog2(RptMax);

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RpW-1:0] RdLast = RpW'(REPEAT_DELAY - 1);
  localparam logic [RpW-1:0] RrLast = RpW'(REPEAT_RATE - 1);

  localparam logic [4:0] HourLo  = (HOUR_MODE_24 != 0) ? 5'd0  : 5'd1;
  localparam logic [4:0] HourHi  = (HOUR_MODE_24 != 0) ? 5'd23 : 5'd12;
  localparam logic [4:0] HourRst = (HOUR_MODE_24 != 0) ? 5'd0  : 5'd12;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDelay  = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;

  logic           sync1_q, sync2_q;
  logic           clean_q, clean_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]     state_q, state_d;
  logic [RpW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic           set_en_q;
  logic [4:0]     h_q, h_d;
  logic [5:0]     m_q, m_d, s_q, s_d;
  logic           chg_q, chg_d;
  logic           strobe_q;
  logic           step, seed, apply;
  logic [4:0]     h_step, h_seed;

  function automatic logic [5:0] ms_step(input logic [5:0] v, input logic dn);
    if (dn) return (v == 6'd0) ? 6'd59 : v - 6'd1;
    else    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // Clean button toggles only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    clean_d  = clean_q;
    db_cnt_d = '0;
    if (sync2_q != clean_q) begin
      if (db_cnt_q == DbLast) clean_d = ~clean_q;
      else                    db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  // Hold FSM; a falling clean button beats a coinciding repeat step.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    step      = 1'b0;
    case (state_q)
      StIdle: begin
        if (clean_q) begin
          step      = 1'b1;
          state_d   = StDelay;
          rpt_cnt_d = '0;
        end
      end
      StDelay: begin
        if (!clean_q) begin
          state_d   = StIdle;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RdLast) begin
          step      = 1'b1;
          state_d   = StRepeat;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RpW'(1);
        end
      end
      StRepeat: begin
        if (!clean_q) begin
          state_d   = StIdle;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RrLast) begin
          step      = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RpW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        rpt_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    seed  = set_en & ~set_en_q;
    apply = step & set_en & (field_sel != 2'b11) & ~seed;

    if (dir) h_step = (h_q == HourLo) ? HourHi : h_q - 5'd1;
    else     h_step = (h_q >= HourHi) ? HourLo : h_q + 5'd1;

    h_seed = ((cur_h > HourHi) || ((HOUR_MODE_24 == 0) && (cur_h == 5'd0))) ? HourLo : cur_h;

    h_d = h_q;
    m_d = m_q;
    s_d = s_q;
    if (seed) begin
      h_d = h_seed;
      m_d = (cur_m > 6'd59) ? 6'd0 : cur_m;
      s_d = (cur_s > 6'd59) ? 6'd0 : cur_s;
    end else if (apply) begin
      case (field_sel)
        2'b00:   h_d = h_step;
        2'b01:   m_d = ms_step(m_q, dir);
        2'b10:   s_d = ms_step(s_q, dir);
        default: ;
      endcase
    end
    chg_d = (h_d != h_q) | (m_d != m_q) | (s_d != s_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      clean_q   <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= StIdle;
      rpt_cnt_q <= '0;
      set_en_q  <= 1'b0;
      h_q       <= HourRst;
      m_q       <= 6'd0;
      s_q       <= 6'd0;
      chg_q     <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      sync1_q   <= pb;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      set_en_q  <= set_en;
      h_q       <= h_d;
      m_q       <= m_d;
      s_q       <= s_d;
      chg_q     <= chg_d;
      strobe_q  <= chg_q;
    end
  end

  assign h_in       = h_q;
  assign m_in       = m_q;
  assign s_in       = s_q;
  assign set_strobe = strobe_q;

endmodule
